// File: rtl/ec_result_collector.sv
// ec_result_collector: drains the fixpnt, flags and digits FIFOs in lockstep,
// packs each entry into a 64-bit record and offers it on a valid/ready port.
// Ports: clk/reset_in (sync, active high); start/expected_cnt begin a batch;
//   fix_rd_used/flags_rd_used gate popping; fix_*/ec_* are FIFO q outputs;
//   rd_req pops all three FIFOs; rec_valid/rec_ready/rec_data carry records;
//   cor/uncor/mal_cnt, rec_cnt, batch_done report per-batch progress.
// Build option: define EC_COLLECT_STATS_EN to build the error statistics
//   counters; otherwise cor_cnt/uncor_cnt/mal_cnt are tied to zero.
module ec_result_collector #(
  parameter int RESULT_CNT_W = 20,
  parameter int STAT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset_in,
  input  logic                    start,
  input  logic [RESULT_CNT_W-1:0] expected_cnt,
  input  logic [9:0]              fix_rd_used,
  input  logic [8:0]              flags_rd_used,
  input  logic                    fix_sign,
  input  logic                    fix_ov1,
  input  logic [31:0]             fix_data,
  input  logic [2:0]              ec_flags,
  input  logic [19:0]             ec_err_digs,
  output logic                    rd_req,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [63:0]             rec_data,
  output logic [STAT_W-1:0]       cor_cnt,
  output logic [STAT_W-1:0]       uncor_cnt,
  output logic [STAT_W-1:0]       mal_cnt,
  output logic [RESULT_CNT_W-1:0] rec_cnt,
  output logic                    batch_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_OUT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic avail;
  logic accept;
  logic [RESULT_CNT_W-1:0] expected_q;

  assign avail  = (fix_rd_used != '0) && (flags_rd_used != '0);
  assign accept = (state_q == S_OUT) && rec_ready;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_req    = 1'b0;
    rec_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (avail) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        rd_req  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        rec_valid = 1'b1;
        if (rec_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Non-showahead FIFOs: q is valid the cycle after rd_req.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      rec_data <= '0;
    end else if (state_q == S_WAIT) begin
      rec_data <= {7'b0, ec_flags, fix_ov1, fix_sign,
                   ec_err_digs, fix_data};
    end
  end

  // A start coinciding with an accept counts that record in the new batch.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      expected_q <= '0;
      rec_cnt    <= '0;
    end else if (start) begin
      expected_q <= expected_cnt;
      rec_cnt    <= {{(RESULT_CNT_W-1){1'b0}}, accept};
    end else if (accept && (rec_cnt != '1)) begin
      rec_cnt <= rec_cnt + 1'b1;
    end
  end

  assign batch_done = (rec_cnt == expected_q);

`ifdef EC_COLLECT_STATS_EN
  logic [STAT_W-1:0] cor_q;
  logic [STAT_W-1:0] unc_q;
  logic [STAT_W-1:0] mal_q;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] c,
    input logic              b
  );
    return (b && (c != '1)) ? c + 1'b1 : c;
  endfunction

  // Flags come from the held record, not the live FIFO q.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      cor_q <= '0;
      unc_q <= '0;
      mal_q <= '0;
    end else if (start) begin
      cor_q <= {{(STAT_W-1){1'b0}}, accept & rec_data[54]};
      unc_q <= {{(STAT_W-1){1'b0}}, accept & rec_data[55]};
      mal_q <= {{(STAT_W-1){1'b0}}, accept & rec_data[56]};
    end else if (accept) begin
      cor_q <= sat_inc(cor_q, rec_data[54]);
      unc_q <= sat_inc(unc_q, rec_data[55]);
      mal_q <= sat_inc(mal_q, rec_data[56]);
    end
  end

  assign cor_cnt   = cor_q;
  assign uncor_cnt = unc_q;
  assign mal_cnt   = mal_q;
`else
  assign cor_cnt   = '0;
  assign uncor_cnt = '0;
  assign mal_cnt   = '0;
`endif

endmodule

// File: tb/tb_ec_result_collector.sv
// tb_ec_result_collector: scoreboard bench for ec_result_collector.
// Models the three FIFOs and the batch counters; small counter widths.
module tb_ec_result_collector;

  localparam int CW = 4;
  localparam int SW = 4;
`ifdef EC_COLLECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_in;
  logic          start;
  logic [CW-1:0] expected_cnt;
  logic [9:0]    fix_rd_used;
  logic [8:0]    flags_rd_used;
  logic          fix_sign;
  logic          fix_ov1;
  logic [31:0]   fix_data;
  logic [2:0]    ec_flags;
  logic [19:0]   ec_err_digs;
  logic          rd_req;
  logic          rec_valid;
  logic          rec_ready;
  logic [63:0]   rec_data;
  logic [SW-1:0] cor_cnt;
  logic [SW-1:0] uncor_cnt;
  logic [SW-1:0] mal_cnt;
  logic [CW-1:0] rec_cnt;
  logic          batch_done;

  always #5 clk = ~clk;

  ec_result_collector #(
    .RESULT_CNT_W(CW),
    .STAT_W      (SW)
  ) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .start        (start),
    .expected_cnt (expected_cnt),
    .fix_rd_used  (fix_rd_used),
    .flags_rd_used(flags_rd_used),
    .fix_sign     (fix_sign),
    .fix_ov1      (fix_ov1),
    .fix_data     (fix_data),
    .ec_flags     (ec_flags),
    .ec_err_digs  (ec_err_digs),
    .rd_req       (rd_req),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_data     (rec_data),
    .cor_cnt      (cor_cnt),
    .uncor_cnt    (uncor_cnt),
    .mal_cnt      (mal_cnt),
    .rec_cnt      (rec_cnt),
    .batch_done   (batch_done)
  );

  typedef struct {
    logic        sign;
    logic        ov1;
    logic [31:0] data;
    logic [2:0]  flags;
    logic [19:0] digs;
  } ent_t;

  ent_t        fq[$];
  logic [63:0] sb[$];

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] m_rec = '0;
  logic [CW-1:0] m_exp = '0;
  logic [SW-1:0] m_cor = '0;
  logic [SW-1:0] m_unc = '0;
  logic [SW-1:0] m_mal = '0;
  int            inflight = 0;
  int            rd_seen = 0;
  bit            force_used = 1'b0;
  logic          s_rd;
  logic          s_valid;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] sinc(input logic [SW-1:0] c,
                                         input logic b);
    return (b && c != {SW{1'b1}}) ? c + 1'b1 : c;
  endfunction

  function automatic logic [63:0] pack(input ent_t e);
    return {7'b0, e.flags, e.ov1, e.sign, e.digs, e.data};
  endfunction

  task automatic set_used();
    if (!force_used) begin
      fix_rd_used   = 10'(fq.size());
      flags_rd_used = 9'(fq.size());
    end
  endtask

  task automatic push(input logic [31:0] d, input logic s,
                      input logic o, input logic [2:0] f,
                      input logic [19:0] g);
    ent_t e;
    e.data  = d;
    e.sign  = s;
    e.ov1   = o;
    e.flags = f;
    e.digs  = g;
    fq.push_back(e);
    sb.push_back(pack(e));
    set_used();
  endtask

  // One clock: check at negedge, advance model, then model FIFO pop.
  task automatic step();
    logic        acc;
    logic        pop;
    logic [63:0] er;
    ent_t        e;
    @(negedge clk);
    s_rd    = rd_req;
    s_valid = rec_valid;
    acc     = (rec_valid === 1'b1) && rec_ready;
    pop     = (rd_req === 1'b1);
    er      = '0;
    if (!reset_in) begin
      chk("rec_cnt", rec_cnt, m_rec);
      chk("batch_done", batch_done, m_rec == m_exp);
      chk("cor_cnt", cor_cnt, STATS ? m_cor : '0);
      chk("uncor_cnt", uncor_cnt, STATS ? m_unc : '0);
      chk("mal_cnt", mal_cnt, STATS ? m_mal : '0);
      chk("rd_guard", rd_req &&
          (fix_rd_used == 0 || flags_rd_used == 0), 0);
      if (acc) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          er = sb.pop_front();
          chk("rec_data", rec_data, er);
          inflight--;
        end
      end
    end
    if (pop) begin
      rd_seen++;
      inflight++;
    end
    if (reset_in) begin
      m_rec = '0;
      m_exp = '0;
      m_cor = '0;
      m_unc = '0;
      m_mal = '0;
      repeat (inflight) begin
        if (sb.size() != 0) void'(sb.pop_front());
      end
      inflight = 0;
    end else if (start) begin
      m_exp = expected_cnt;
      m_rec = CW'(acc);
      m_cor = SW'(acc & er[54]);
      m_unc = SW'(acc & er[55]);
      m_mal = SW'(acc & er[56]);
    end else if (acc) begin
      if (m_rec != {CW{1'b1}}) m_rec = m_rec + 1'b1;
      m_cor = sinc(m_cor, er[54]);
      m_unc = sinc(m_unc, er[55]);
      m_mal = sinc(m_mal, er[56]);
    end
    @(posedge clk);
    #1;
    if (pop && fq.size() != 0) begin
      e           = fq.pop_front();
      fix_data    = e.data;
      fix_sign    = e.sign;
      fix_ov1     = e.ov1;
      ec_flags    = e.flags;
      ec_err_digs = e.digs;
    end
    set_used();
  endtask

  task automatic wait_valid(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (s_valid === 1'b1) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && (sb.size() != 0); i++) begin
      step();
    end
    chk(tag, sb.size(), 0);
    step();
    step();
  endtask

  task automatic begin_batch(input logic [CW-1:0] n);
    expected_cnt = n;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  logic [5:0]  h_rd;
  logic [5:0]  h_v;
  logic [63:0] d0;
  int          rd0;
  bit          seen;

  initial begin
    reset_in     = 1'b1;
    start        = 1'b0;
    expected_cnt = '0;
    rec_ready    = 1'b0;
    fix_sign     = 1'b0;
    fix_ov1      = 1'b0;
    fix_data     = '0;
    ec_flags     = '0;
    ec_err_digs  = '0;
    set_used();
    step();
    step();
    chk("rst_rd_req", rd_req, 0);
    chk("rst_valid", rec_valid, 0);
    chk("rst_data", rec_data, 0);
    chk("rst_rec_cnt", rec_cnt, 0);
    chk("rst_done", batch_done, 1);
    reset_in = 1'b0;

    // Basic pop and latency
    begin_batch(4'd1);
    rec_ready = 1'b1;
    push(32'hDEADBEEF, 1'b1, 1'b0, 3'b001, 20'h00003);
    h_rd = '0;
    h_v  = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      h_rd[i] = s_rd;
      h_v[i]  = s_valid;
    end
    chk("basic_rd_pulse", h_rd, 6'b000010);
    chk("basic_valid_lat", h_v, 6'b001000);
    chk("basic_rec_cnt", rec_cnt, 1);
    chk("basic_cor", cor_cnt, STATS ? 1 : 0);
    chk("basic_done", batch_done, 1);

    // Backpressure
    rec_ready = 1'b0;
    push(32'h12345678, 1'b0, 1'b1, 3'b010, 20'hABCDE);
    push(32'h0F0F0F0F, 1'b1, 1'b1, 3'b111, 20'hFFFFF);
    wait_valid("bp_valid");
    d0 = rec_data;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_stable", rec_data, d0);
      chk("bp_no_rd", s_rd, 0);
    end
    rec_ready = 1'b1;
    step();
    step();
    chk("bp_idle_rd", s_rd, 0);
    step();
    chk("bp_next_rd", s_rd, 1);
    drain("bp_drain");

    // Empty guard: flags FIFO empty
    force_used    = 1'b1;
    fix_rd_used   = 10'd5;
    flags_rd_used = 9'd0;
    rd0           = rd_seen;
    for (int i = 0; i < 8; i++) step();
    chk("empty_guard", rd_seen - rd0, 0);
    force_used = 1'b0;
    set_used();

    // Saturation
    begin_batch(4'd10);
    for (int i = 0; i < 20; i++) begin
      push($urandom, 1'($urandom), 1'($urandom), 3'b010,
           20'($urandom));
    end
    drain("sat_drain");
    chk("sat_rec_cnt", rec_cnt, 15);
    chk("sat_uncor", uncor_cnt, STATS ? 15 : 0);
    chk("sat_done", batch_done, 0);

    // Restart during WAIT
    begin_batch(4'd1);
    push(32'hCAFEF00D, 1'b0, 1'b0, 3'b001, 20'h12345);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (s_rd === 1'b1) seen = 1'b1;
    end
    chk("restart_rd", seen, 1);
    expected_cnt = 4'd2;
    start        = 1'b1;
    step();
    start        = 1'b0;
    drain("restart_drain");
    chk("restart_cnt", rec_cnt, 1);
    chk("restart_done", batch_done, 0);

    // Start coinciding with accept
    rec_ready = 1'b0;
    push(32'h00000001, 1'b0, 1'b0, 3'b100, 20'h00001);
    wait_valid("coinc_valid");
    expected_cnt = 4'd3;
    start        = 1'b1;
    rec_ready    = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("coinc_cnt", rec_cnt, 1);
    chk("coinc_mal", mal_cnt, STATS ? 1 : 0);
    chk("coinc_done", batch_done, 0);

    // Reset during OUT
    rec_ready = 1'b0;
    push(32'h55AA55AA, 1'b1, 1'b0, 3'b011, 20'h0000F);
    wait_valid("rstmid_valid");
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    chk("rstmid_valid", rec_valid, 0);
    chk("rstmid_cnt", rec_cnt, 0);
    chk("rstmid_data", rec_data, 0);
    chk("rstmid_mal", mal_cnt, 0);
    step();
    chk("rstmid_done", batch_done, 1);
    chk("rstmid_sb", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
